cam_forwarder_multi: RTL and testbench

// Parametrised successor of the two-stage CAM forwarder: keeps the last DEPTH write/delete ops still in flight
// to the CAM/table pipeline and corrects a lookup result whose key matches one of them. Newest matching op wins.

---
 rtl/cam_forwarder_multi.sv | 125 ++++++++++++
 tb/tb_cam_forwarder_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_forwarder_multi.sv
// Forwarding window in front of a CAM lookup: tracks the last DEPTH write/delete ops still in flight
// and corrects a lookup whose key matches one of them (newest matching op wins).
module cam_forwarder_multi #(
  parameter int DATA_WIDTH   = 4,
  parameter int KEY_WIDTH    = 2,
  parameter int DEPTH        = 2,
  parameter int REGISTER_OUT = 0,
  parameter int COUNT_WIDTH  = 16,
  localparam int HW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   flush_i,
  input  logic [KEY_WIDTH-1:0]   new_key_i,
  input  logic [DATA_WIDTH-1:0]  new_data_i,
  input  logic                   new_valid_i,
  input  logic [KEY_WIDTH-1:0]   forward_key_i,
  input  logic [DATA_WIDTH-1:0]  forward_data_i,
  input  logic                   forward_write_i,
  input  logic                   forward_del_i,
  output logic [DATA_WIDTH-1:0]  corrected_data_o,
  output logic                   correct_valid_o,
  output logic                   forward_hit_o,
  output logic [HW-1:0]          hit_depth_o,
  output logic [COUNT_WIDTH-1:0] hit_count_o
);

  logic [KEY_WIDTH-1:0]  key_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic                  write_q [DEPTH];
  logic                  del_q   [DEPTH];

  logic [DEPTH-1:0]      match;
  logic                  comb_hit;
  logic [HW-1:0]         comb_idx;
  logic [DATA_WIDTH-1:0] comb_data;
  logic                  comb_valid;

  // Flush only clears the op bits; stale key/data left behind are harmless once inactive.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i]   <= '0;
        data_q[i]  <= '0;
        write_q[i] <= 1'b0;
        del_q[i]   <= 1'b0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        write_q[i] <= 1'b0;
        del_q[i]   <= 1'b0;
      end
    end else if (clk_en) begin
      for (int i = 1; i < DEPTH; i++) begin
        key_q[i]   <= key_q[i-1];
        data_q[i]  <= data_q[i-1];
        write_q[i] <= write_q[i-1];
        del_q[i]   <= del_q[i-1];
      end
      key_q[0]   <= forward_key_i;
      data_q[0]  <= forward_data_i;
      write_q[0] <= forward_write_i;
      del_q[0]   <= forward_del_i;
    end
  end

  // An entry only counts when exactly one of write/del is set.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = (write_q[i] ^ del_q[i]) && (key_q[i] == new_key_i);
    end
  end

  // Scan oldest to newest so the lowest matching index is the last assignment and wins.
  always_comb begin
    comb_hit   = 1'b0;
    comb_idx   = '0;
    comb_data  = new_data_i;
    comb_valid = new_valid_i;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        comb_hit   = 1'b1;
        comb_idx   = HW'(i);
        comb_data  = write_q[i] ? data_q[i] : new_data_i;
        comb_valid = write_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_o <= '0;
    end else if (clk_en && comb_hit && (hit_count_o != {COUNT_WIDTH{1'b1}})) begin
      hit_count_o <= hit_count_o + 1'b1;
    end
  end

  generate
    if (REGISTER_OUT != 0) begin : g_reg_out
      always_ff @(posedge clk) begin
        if (reset) begin
          corrected_data_o <= '0;
          correct_valid_o  <= 1'b0;
          forward_hit_o    <= 1'b0;
          hit_depth_o      <= '0;
        end else if (clk_en) begin
          corrected_data_o <= comb_data;
          correct_valid_o  <= comb_valid;
          forward_hit_o    <= comb_hit;
          hit_depth_o      <= comb_idx;
        end
      end
    end else begin : g_comb_out
      always_comb begin
        corrected_data_o = comb_data;
        correct_valid_o  = comb_valid;
        forward_hit_o    = comb_hit;
        hit_depth_o      = comb_idx;
      end
    end
  endgenerate

endmodule

// File: tb/tb_cam_forwarder_multi.sv
// Directed bench for cam_forwarder_multi: three configurations share one stimulus stream;
// each scenario starts from reset and checks the instance it targets.
module tb_cam_forwarder_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b0;
  logic       flush_i = 1'b0;
  logic [1:0] new_key_i = '0;
  logic [3:0] new_data_i = '0;
  logic       new_valid_i = 1'b0;
  logic [1:0] forward_key_i = '0;
  logic [3:0] forward_data_i = '0;
  logic       forward_write_i = 1'b0;
  logic       forward_del_i = 1'b0;

  logic [3:0]  d2_data, d4_data, dr_data;
  logic        d2_valid, d4_valid, dr_valid;
  logic        d2_hit, d4_hit, dr_hit;
  logic        d2_depth, dr_depth;
  logic [1:0]  d4_depth;
  logic [15:0] d2_count, d4_count;
  logic [1:0]  dr_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cam_forwarder_multi #(.DEPTH(2), .REGISTER_OUT(0), .COUNT_WIDTH(16)) u2 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush_i),
    .new_key_i(new_key_i), .new_data_i(new_data_i), .new_valid_i(new_valid_i),
    .forward_key_i(forward_key_i), .forward_data_i(forward_data_i),
    .forward_write_i(forward_write_i), .forward_del_i(forward_del_i),
    .corrected_data_o(d2_data), .correct_valid_o(d2_valid), .forward_hit_o(d2_hit),
    .hit_depth_o(d2_depth), .hit_count_o(d2_count));

  cam_forwarder_multi #(.DEPTH(4), .REGISTER_OUT(0), .COUNT_WIDTH(16)) u4 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush_i),
    .new_key_i(new_key_i), .new_data_i(new_data_i), .new_valid_i(new_valid_i),
    .forward_key_i(forward_key_i), .forward_data_i(forward_data_i),
    .forward_write_i(forward_write_i), .forward_del_i(forward_del_i),
    .corrected_data_o(d4_data), .correct_valid_o(d4_valid), .forward_hit_o(d4_hit),
    .hit_depth_o(d4_depth), .hit_count_o(d4_count));

  cam_forwarder_multi #(.DEPTH(2), .REGISTER_OUT(1), .COUNT_WIDTH(2)) ur (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush_i),
    .new_key_i(new_key_i), .new_data_i(new_data_i), .new_valid_i(new_valid_i),
    .forward_key_i(forward_key_i), .forward_data_i(forward_data_i),
    .forward_write_i(forward_write_i), .forward_del_i(forward_del_i),
    .corrected_data_o(dr_data), .correct_valid_o(dr_valid), .forward_hit_o(dr_hit),
    .hit_depth_o(dr_depth), .hit_count_o(dr_count));

  typedef struct {
    logic       ce, fl;
    logic [1:0] nk;
    logic [3:0] nd;
    logic       nv;
    logic [1:0] fk;
    logic [3:0] fd;
    logic       fw, fdl;
    logic [3:0] ed;
    logic       ev, eh;
    logic [1:0] edp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle before the next rising edge.
  task automatic drive(input logic ce, input logic fl, input logic [1:0] nk, input logic [3:0] nd,
                       input logic nv, input logic [1:0] fk, input logic [3:0] fd,
                       input logic fw, input logic fdl);
    @(negedge clk);
    clk_en = ce; flush_i = fl;
    new_key_i = nk; new_data_i = nd; new_valid_i = nv;
    forward_key_i = fk; forward_data_i = fd; forward_write_i = fw; forward_del_i = fdl;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clk_en = 1'b0; flush_i = 1'b0;
    new_key_i = '0; new_data_i = '0; new_valid_i = 1'b0;
    forward_key_i = '0; forward_data_i = '0; forward_write_i = 1'b0; forward_del_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk4(input string nm, input int ed, input int ev, input int eh, input int edp);
    chk({nm, ".data"}, d4_data, ed);
    chk({nm, ".valid"}, d4_valid, ev);
    chk({nm, ".hit"}, d4_hit, eh);
    chk({nm, ".depth"}, d4_depth, edp);
  endtask

  task automatic chkr(input string nm, input int ed, input int ev, input int eh, input int edp);
    chk({nm, ".data"}, dr_data, ed);
    chk({nm, ".valid"}, dr_valid, ev);
    chk({nm, ".hit"}, dr_hit, eh);
    chk({nm, ".depth"}, dr_depth, edp);
  endtask

  initial begin
    //          ce fl nk nd  nv fk fd  fw fdl  ed ev eh edp
    tbl[0]  = '{1, 0, 2, 1,  1, 2, 7,  1, 0,   1, 1, 0, 0};
    tbl[1]  = '{1, 0, 2, 1,  0, 2, 0,  0, 1,   7, 1, 1, 0};
    tbl[2]  = '{1, 0, 2, 3,  1, 2, 9,  1, 0,   3, 0, 1, 0};
    tbl[3]  = '{1, 0, 2, 3,  0, 0, 0,  0, 0,   9, 1, 1, 0};
    tbl[4]  = '{0, 0, 2, 3,  0, 0, 0,  0, 0,   9, 1, 1, 1};
    tbl[5]  = '{1, 0, 2, 3,  0, 0, 0,  0, 0,   9, 1, 1, 1};
    tbl[6]  = '{0, 0, 2, 6,  1, 0, 0,  0, 0,   9, 1, 1, 2};
    tbl[7]  = '{1, 0, 3, 4,  1, 3, 4,  1, 0,   4, 1, 0, 0};
    tbl[8]  = '{1, 0, 2, 0,  0, 3, 0,  0, 1,   9, 1, 1, 3};
    tbl[9]  = '{0, 0, 3, 4,  1, 0, 0,  0, 0,   4, 0, 1, 0};
    tbl[10] = '{0, 0, 2, 5,  1, 0, 0,  0, 0,   5, 1, 0, 0};
    tbl[11] = '{1, 0, 1, 2,  0, 1, 15, 1, 1,   2, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 2,  0, 0, 0,  0, 0,   2, 0, 0, 0};
    tbl[13] = '{0, 0, 3, 8,  1, 0, 0,  0, 0,   8, 0, 1, 1};

    // Reset state: registered outputs and counters clear, unregistered outputs pass raw data through.
    do_reset();
    reset = 1'b1;
    new_key_i = 2'd1; new_data_i = 4'd6; new_valid_i = 1'b1;
    @(posedge clk); #1;
    chkr("rst.ur", 0, 0, 0, 0);
    chk("rst.ur.count", dr_count, 0);
    chk("rst.u4.count", d4_count, 0);
    chk("rst.u2.count", d2_count, 0);
    chk4("rst.u4", 6, 1, 0, 0);

    // DEPTH=4 table: write/delete/rewrite, aging, delete-newest, write=del=1 ignored.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ce, tbl[i].fl, tbl[i].nk, tbl[i].nd, tbl[i].nv,
            tbl[i].fk, tbl[i].fd, tbl[i].fw, tbl[i].fdl);
      chk4($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].ev, tbl[i].eh, tbl[i].edp);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("tbl.count", d4_count, 5);

    // Legacy two-stage behaviour on the DEPTH=2 instance.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    drive(1, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("legacy.d0.hit", d2_hit, 1);
    chk("legacy.d0.data", d2_data, 5);
    drive(0, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("legacy.data", d2_data, 5);
    chk("legacy.valid", d2_valid, 1);
    chk("legacy.hit", d2_hit, 1);
    chk("legacy.depth", d2_depth, 1);
    drive(1, 0, 1, 3, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("legacy.aged.hit", d2_hit, 0);
    chk("legacy.aged.data", d2_data, 3);

    // Stall then age out on DEPTH=4.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 6, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
      chk4($sformatf("stall%0d", i), 6, 1, 1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
      chk4($sformatf("age%0d", i), 6, 1, 1, i);
    end
    drive(0, 0, 1, 2, 1, 0, 0, 0, 0);
    chk4("aged", 2, 1, 0, 0);
    chk("aged.count", d4_count, 4);

    // Flush with clk_en low, then flush coinciding with a counted hit.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 3, 1, 0, 2'(i), 4'(i + 8), 1, 0);
      chk4($sformatf("fill%0d", i), 1, 0, 0, 0);
    end
    drive(0, 0, 2, 1, 0, 0, 0, 0, 0);
    chk4("prefl", 10, 1, 1, 1);
    drive(0, 1, 0, 1, 0, 1, 15, 1, 0);
    chk4("fl.same", 8, 1, 1, 3);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 2'(k), 4'(k + 4), 1'(k), 0, 0, 0, 0);
      chk4($sformatf("postfl%0d", k), k + 4, k & 1, 0, 0);
    end
    chk("fl.count", d4_count, 0);
    drive(1, 0, 0, 1, 0, 2, 3, 1, 0);
    drive(1, 1, 2, 0, 0, 1, 1, 1, 0);
    chk4("flhit", 3, 1, 1, 0);
    drive(0, 0, 2, 0, 0, 0, 0, 0, 0);
    chk4("flhit.after", 0, 0, 0, 0);
    chk("flhit.count", d4_count, 1);

    // Registered outputs, saturating 2-bit counter, write=del=1 never hits.
    do_reset();
    drive(1, 0, 1, 2, 0, 1, 9, 1, 0);
    chkr("reg0", 0, 0, 0, 0);
    for (int n = 1; n <= 5; n++) begin
      drive(1, 0, 1, 0, 0, 1, 4'(n), 1, 0);
      if (n == 1) chkr("reg1", 2, 0, 0, 0);
      else chkr($sformatf("reg%0d", n), (n == 2) ? 9 : n - 2, 1, 1, 0);
      chk($sformatf("reg%0d.count", n), dr_count, (n - 1 > 3) ? 3 : n - 1);
    end
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chkr("hold0", 4, 1, 1, 0);
    drive(0, 0, 2, 0, 0, 0, 0, 0, 0);
    chkr("hold1", 4, 1, 1, 0);
    chk("sat.count", dr_count, 3);
    drive(1, 0, 2, 6, 1, 2, 7, 1, 1);
    drive(1, 0, 2, 6, 1, 0, 0, 0, 0);
    chkr("both0", 6, 1, 0, 0);
    drive(1, 0, 2, 6, 1, 0, 0, 0, 0);
    chkr("both1", 6, 1, 0, 0);
    drive(0, 0, 2, 6, 1, 0, 0, 0, 0);
    chkr("both2", 6, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
